// File: rtl/tri_ram_arbiter.sv
// rtl/tri_ram_arbiter.sv - two-lane burst read arbiter for the triangle RAM
//
// Purpose:
//   Two traversal lanes request short read bursts (1..4 words) from one
//   single-ported triangle RAM. Only one burst runs at a time. When both
//   lanes ask at once, a round-robin pointer picks the winner. Responses come
//   back on one shared data bus, with a valid flag for each lane.
//
// Ports:
//   clock              in   single clock, rising edge
//   reset              in   synchronous active-low reset
//   laneN_req_valid    in   lane N burst request
//   laneN_req_addr     in   burst start word address (ADDR_W)
//   laneN_req_len      in   burst length minus one (2 bits)
//   laneN_req_ready    out  request accepted when valid && ready
//   mem_en             out  RAM read enable, one word per cycle
//   mem_addr           out  RAM read address (ADDR_W)
//   mem_rdata          in   RAM read data, one cycle after mem_en (DATA_W)
//   laneN_rsp_valid    out  response word on rsp_data belongs to lane N
//   rsp_last           out  final word of a burst
//   rsp_data           out  shared response data (DATA_W)
//   arb_busy           out  burst active or response still in flight
//
// Optional feature (macro TRI_ARB_PERF_EN):
//   perf_clear         in   clears both performance counters
//   perf_conflict_cnt  out  cycles with both lanes requesting and one held off
//   perf_busy_cnt      out  cycles with arb_busy high

module tri_ram_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 128
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              lane0_req_valid,
   input  logic [ADDR_W-1:0] lane0_req_addr,
   input  logic [1:0]        lane0_req_len,
   output logic              lane0_req_ready,
   input  logic              lane1_req_valid,
   input  logic [ADDR_W-1:0] lane1_req_addr,
   input  logic [1:0]        lane1_req_len,
   output logic              lane1_req_ready,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              lane0_rsp_valid,
   output logic              lane1_rsp_valid,
   output logic              rsp_last,
   output logic [DATA_W-1:0] rsp_data,
`ifdef TRI_ARB_PERF_EN
   input  logic              perf_clear,
   output logic [31:0]       perf_conflict_cnt,
   output logic [31:0]       perf_busy_cnt,
`endif
   output logic              arb_busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BURST0 = 2'd1;
   localparam logic [1:0] BURST1 = 2'd2;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [1:0]        state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic [1:0]        beat_q, beat_d;
   logic [1:0]        len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              mem_en_q, mem_en_d;
   logic              rsp0_q, rsp0_d;
   logic              rsp1_q, rsp1_d;
   logic              last_q, last_d;

   logic              grant0, grant1;
   logic              last_beat;

   // Grants only in IDLE. rr_ptr breaks the tie when both lanes ask.
   // Ready depends on req_valid through logic only. mem_en and mem_addr
   // are registered, so req_valid has no combinational path to the RAM.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset && (state_q == IDLE)) begin
         grant0 = lane0_req_valid && (!lane1_req_valid || !rr_ptr_q);
         grant1 = lane1_req_valid && (!lane0_req_valid ||  rr_ptr_q);
      end
   end

   assign lane0_req_ready = grant0;
   assign lane1_req_ready = grant1;

   assign last_beat = (beat_q == len_q);

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      beat_d   = beat_q;
      len_d    = len_q;
      addr_d   = addr_q;
      mem_en_d = 1'b0;
      // The response for the beat issued this cycle appears next cycle.
      // It is tagged with the lane that owns the current burst.
      rsp0_d   = mem_en_q && (state_q == BURST0);
      rsp1_d   = mem_en_q && (state_q == BURST1);
      last_d   = mem_en_q && last_beat;
      case (state_q)
         IDLE: begin
            if (grant0 || grant1) begin
               state_d  = grant1 ? BURST1 : BURST0;
               addr_d   = grant1 ? lane1_req_addr : lane0_req_addr;
               len_d    = grant1 ? lane1_req_len  : lane0_req_len;
               beat_d   = 2'd0;
               mem_en_d = 1'b1;
               rr_ptr_d = grant0;   // point at the other lane
            end
         end
         BURST0, BURST1: begin
            if (last_beat) begin
               // The address stays on the final beat until the next burst.
               state_d = IDLE;
               beat_d  = 2'd0;
            end else begin
               beat_d   = beat_q + 2'd1;
               addr_d   = addr_q + ADDR_ONE;  // wraps modulo 2^ADDR_W
               mem_en_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= 1'b0;
         beat_q   <= 2'd0;
         len_q    <= 2'd0;
         addr_q   <= '0;
         mem_en_q <= 1'b0;
         rsp0_q   <= 1'b0;
         rsp1_q   <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         beat_q   <= beat_d;
         len_q    <= len_d;
         addr_q   <= addr_d;
         mem_en_q <= mem_en_d;
         rsp0_q   <= rsp0_d;
         rsp1_q   <= rsp1_d;
         last_q   <= last_d;
      end
   end

   assign mem_en          = mem_en_q;
   assign mem_addr        = addr_q;
   assign lane0_rsp_valid = rsp0_q;
   assign lane1_rsp_valid = rsp1_q;
   assign rsp_last        = last_q;
   assign rsp_data        = mem_rdata;
   assign arb_busy        = (state_q != IDLE) || rsp0_q || rsp1_q;

`ifdef TRI_ARB_PERF_EN
   logic [31:0] conflict_q;
   logic [31:0] busy_q;
   logic        conflict;

   assign conflict = lane0_req_valid && lane1_req_valid && !(grant0 && grant1);

   // Clear has priority over counting. Both counters saturate.
   always_ff @(posedge clock) begin
      if (!reset || perf_clear) begin
         conflict_q <= 32'd0;
         busy_q     <= 32'd0;
      end else begin
         if (conflict && (conflict_q != 32'hFFFF_FFFF)) begin
            conflict_q <= conflict_q + 32'd1;
         end
         if (arb_busy && (busy_q != 32'hFFFF_FFFF)) begin
            busy_q <= busy_q + 32'd1;
         end
      end
   end

   assign perf_conflict_cnt = conflict_q;
   assign perf_busy_cnt     = busy_q;
`endif

endmodule
